// File: rtl/execute_stage.sv
// execute_stage: RV32 EX stage with operand forwarding, ALU, branch/jump resolution,
// a multi-cycle restoring divu/remu unit and the EX/MEM pipeline register.
// Ports: clk, reset (async, active-high); ID/EX control and operands (*_e);
// forwarding selects/values (forward_a_e, forward_b_e, result_w, alu_result_fwd_m);
// pc_src_e/pc_target_e redirect; stall_e front-end hold; ex_mem_* registered outputs.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwrite_e,
    input  logic        memwrite_e,
    input  logic        jump_e,
    input  logic        branch_e,
    input  logic        jalr_e,
    input  logic [1:0]  result_src_e,
    input  logic [3:0]  alu_control_e,
    input  logic        alu_src_e,
    input  logic [2:0]  funct3_e,
    input  logic [31:0] rd1_e,
    input  logic [31:0] rd2_e,
    input  logic [31:0] imm_ext_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] pc_plus_4_e,
    input  logic [4:0]  rd_e,
    input  logic [1:0]  forward_a_e,
    input  logic [1:0]  forward_b_e,
    input  logic [31:0] result_w,
    input  logic [31:0] alu_result_fwd_m,
    output logic        pc_src_e,
    output logic [31:0] pc_target_e,
    output logic        stall_e,
    output logic        ex_mem_regwrite,
    output logic        ex_mem_memwrite,
    output logic [1:0]  ex_mem_result_src,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_writedata,
    output logic [31:0] ex_mem_pc_plus_4,
    output logic [4:0]  ex_mem_rd
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvsr;
    logic [31:0] src_a, fwd_b, src_b, alu_result;
    logic [32:0] rem_sh, rem_diff;
    logic        is_div, cond, ge;

    assign src_a = forward_a_e == 2'b01 ? result_w :
                   forward_a_e == 2'b10 ? alu_result_fwd_m : rd1_e;
    assign fwd_b = forward_b_e == 2'b01 ? result_w :
                   forward_b_e == 2'b10 ? alu_result_fwd_m : rd2_e;
    assign src_b = alu_src_e ? imm_ext_e : fwd_b;

    assign is_div  = alu_control_e == 4'b1100 || alu_control_e == 4'b1101;
    assign stall_e = !reset && (state == BUSY || (state == IDLE && is_div));

    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    assign rem_sh   = {rem, quo[31]};
    assign rem_diff = rem_sh - {1'b0, dvsr};
    assign ge       = !rem_diff[32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
        end else begin
            case (state)
                IDLE: if (is_div) begin
                    quo   <= src_a;
                    rem   <= '0;
                    dvsr  <= src_b;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    rem   <= ge ? rem_diff[31:0] : rem_sh[31:0];
                    quo   <= {quo[30:0], ge};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? DONE : BUSY;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        alu_result = '0;
        case (alu_control_e)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_result = {31'b0, src_a < src_b};
            4'b0111: alu_result = src_a << src_b[4:0];
            4'b1000: alu_result = src_a >> src_b[4:0];
            4'b1001: alu_result = $signed(src_a) >>> src_b[4:0];
            4'b1010: alu_result = src_b;
            4'b1100: alu_result = quo;
            4'b1101: alu_result = rem;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3_e)
            3'b000:  cond = src_a == fwd_b;
            3'b001:  cond = src_a != fwd_b;
            3'b100:  cond = $signed(src_a) < $signed(fwd_b);
            3'b101:  cond = $signed(src_a) >= $signed(fwd_b);
            3'b110:  cond = src_a < fwd_b;
            3'b111:  cond = src_a >= fwd_b;
            default: cond = 1'b0;
        endcase
    end

    assign pc_src_e    = !stall_e && (jump_e || (branch_e && cond));
    assign pc_target_e = jalr_e ? ((src_a + imm_ext_e) & ~32'd1) : pc_e + imm_ext_e;

    // a stalled EX slot drains as a bubble so MEM never sees a half-finished divide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_regwrite   <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_result_src <= '0;
            ex_mem_alu_result <= '0;
            ex_mem_writedata  <= '0;
            ex_mem_pc_plus_4  <= '0;
            ex_mem_rd         <= '0;
        end else begin
            ex_mem_regwrite   <= !stall_e && regwrite_e;
            ex_mem_memwrite   <= !stall_e && memwrite_e;
            ex_mem_result_src <= stall_e ? 2'b00 : result_src_e;
            ex_mem_alu_result <= stall_e ? 32'd0 : alu_result;
            ex_mem_writedata  <= stall_e ? 32'd0 : fwd_b;
            ex_mem_pc_plus_4  <= stall_e ? 32'd0 : pc_plus_4_e;
            ex_mem_rd         <= stall_e ? 5'd0 : rd_e;
        end
    end
endmodule
